// File: rtl/dac_spi_tx_if.sv
// rtl/dac_spi_tx_if.sv - DDS sample stream into the DAC serialiser
interface dac_spi_tx_if;
  logic [7:0] din;
  logic [1:0] pd;
  logic       din_valid;
  logic       din_ready;

  modport master (output din, output pd, output din_valid, input din_ready);
  modport slave  (input din, input pd, input din_valid, output din_ready);
endinterface

// File: rtl/dac_spi_tx.sv
// rtl/dac_spi_tx.sv - serialises one DDS sample per 16-bit SPI frame, counts dropped samples
module dac_spi_tx #(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 2,
  parameter int OVR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  dac_spi_tx_if.slave      smp,
  output logic             dac_sclk,
  output logic             dac_sync_n,
  output logic             dac_din,
  output logic             frame_done,
  output logic [OVR_W-1:0] overrun_cnt
);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t        state, state_n;
  logic [DW-1:0] div_cnt;
  logic [GW-1:0] gap_cnt;
  logic [4:0]    bit_cnt;
  logic [14:0]   shreg;
  logic [15:0]   frame;
  logic          accept, tick, sclk_fall, sclk_rise, frame_end;

  assign smp.din_ready = (state == IDLE) && !rst;
  assign frame = {2'b00, smp.pd, smp.din, 4'b0000};

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    tick      = 1'b0;
    sclk_fall = 1'b0;
    sclk_rise = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (smp.din_valid) begin
          accept  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        tick = (div_cnt == DIV_LAST);
        if (tick) begin
          // the half-period after the 16th falling edge closes the frame instead of rising
          if (dac_sclk) begin
            sclk_fall = 1'b1;
          end else if (bit_cnt == 5'd16) begin
            frame_end = 1'b1;
            state_n   = GAP;
          end else begin
            sclk_rise = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dac_sclk    <= 1'b1;
      dac_sync_n  <= 1'b1;
      dac_din     <= 1'b0;
      frame_done  <= 1'b0;
      overrun_cnt <= '0;
      div_cnt     <= '0;
      gap_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
    end else begin
      state      <= state_n;
      frame_done <= frame_end;

      if (smp.din_valid && !smp.din_ready && (overrun_cnt != '1))
        overrun_cnt <= overrun_cnt + OVR_W'(1);

      if (accept) begin
        shreg      <= frame[14:0];
        dac_din    <= frame[15];
        dac_sync_n <= 1'b0;
        dac_sclk   <= 1'b1;
        div_cnt    <= '0;
        bit_cnt    <= '0;
      end

      if (state == SHIFT) div_cnt <= tick ? '0 : div_cnt + DW'(1);

      if (sclk_fall) begin
        dac_sclk <= 1'b0;
        bit_cnt  <= bit_cnt + 5'd1;
      end

      if (sclk_rise) begin
        dac_sclk <= 1'b1;
        dac_din  <= shreg[14];
        shreg    <= {shreg[13:0], 1'b0};
      end

      if (frame_end) begin
        dac_sclk   <= 1'b1;
        dac_sync_n <= 1'b1;
        dac_din    <= 1'b0;
        gap_cnt    <= '0;
      end

      if (state == GAP) gap_cnt <= gap_cnt + GW'(1);
    end
  end
endmodule
